// File: rtl/aes_128_encipher_block_if.sv
// Block-level bus between the AES core controller/key memory (master) and the
// encipher datapath (slave).
interface aes_128_encipher_block_if;
    logic         next;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [3:0]   round;
    logic [127:0] new_block;
    logic         ready;

    modport master (output next, round_key, block, input round, new_block, ready);
    modport slave  (input next, round_key, block, output round, new_block, ready);
endinterface

// File: rtl/aes_128_encipher_block.sv
// Iterative AES-128 forward cipher datapath with a word-serial shared S-box.
// Define AES_ENC_PARALLEL_SBOX_EN for four S-box words and 2-cycle rounds.
module AES_Sbox (
    input  logic [31:0] sbox,
    output logic [31:0] new_sbox
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign new_sbox[gi*8 +: 8] = sub_byte(sbox[gi*8 +: 8]);
        end
    endgenerate
endmodule

module aes_128_encipher_block (
    input  logic                     clk,
    input  logic                     reset_n,
    aes_128_encipher_block_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} ctrl_t;

    ctrl_t       ctrl_reg, ctrl_next;
    logic [3:0]  round_reg, round_next;
    logic [1:0]  sword_reg, sword_next;
    logic        ready_reg, ready_next;
    logic [31:0] w_reg  [4];
    logic [31:0] w_next [4];
    logic [31:0] sub_word [4];

    logic [127:0] state_flat, shifted, mixed, main_block, init_block;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    assign state_flat = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
    assign shifted    = shift_rows(state_flat);
    assign mixed      = (round_reg < 4'd10) ? mix_columns(shifted) : shifted;
    assign main_block = mixed ^ bus.round_key;
    assign init_block = bus.block ^ bus.round_key;

`ifdef AES_ENC_PARALLEL_SBOX_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            AES_Sbox u_sbox (.sbox(w_reg[gi]), .new_sbox(sub_word[gi]));
        end
    endgenerate
`else
    logic [31:0] sbox_out;
    AES_Sbox u_sbox (.sbox(w_reg[sword_reg]), .new_sbox(sbox_out));
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sub
            assign sub_word[gi] = sbox_out;
        end
    endgenerate
`endif

    always_comb begin
        ctrl_next  = ctrl_reg;
        round_next = round_reg;
        sword_next = sword_reg;
        ready_next = ready_reg;
        for (int i = 0; i < 4; i++) w_next[i] = w_reg[i];

        unique case (ctrl_reg)
            IDLE: begin
                if (bus.next) begin
                    round_next = 4'd0;
                    ready_next = 1'b0;
                    ctrl_next  = INIT;
                end
            end
            INIT: begin
                for (int i = 0; i < 4; i++) w_next[i] = init_block[127-32*i -: 32];
                round_next = 4'd1;
                sword_next = 2'd0;
                ctrl_next  = SBOX;
            end
            SBOX: begin
`ifdef AES_ENC_PARALLEL_SBOX_EN
                for (int i = 0; i < 4; i++) w_next[i] = sub_word[i];
                ctrl_next = MAIN;
`else
                // Only the word currently routed through the shared S-box is written.
                w_next[sword_reg] = sub_word[sword_reg];
                sword_next = sword_reg + 2'd1;
                if (sword_reg == 2'd3) ctrl_next = MAIN;
`endif
            end
            MAIN: begin
                sword_next = 2'd0;
                for (int i = 0; i < 4; i++) w_next[i] = main_block[127-32*i -: 32];
                if (round_reg < 4'd10) begin
                    round_next = round_reg + 4'd1;
                    ctrl_next  = SBOX;
                end else begin
                    ready_next = 1'b1;
                    ctrl_next  = IDLE;
                end
            end
            default: ctrl_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg  <= IDLE;
            round_reg <= 4'd0;
            sword_reg <= 2'd0;
            ready_reg <= 1'b1;
            for (int i = 0; i < 4; i++) w_reg[i] <= '0;
        end else begin
            ctrl_reg  <= ctrl_next;
            round_reg <= round_next;
            sword_reg <= sword_next;
            ready_reg <= ready_next;
            for (int i = 0; i < 4; i++) w_reg[i] <= w_next[i];
        end
    end

    assign bus.round     = round_reg;
    assign bus.new_block = state_flat;
    assign bus.ready     = ready_reg;
endmodule

// File: tb/tb_aes_128_encipher_block.sv
// Self-checking bench: FIPS-197 vectors, control corner cases and random runs
// against a byte-matrix AES reference model.
module tb_aes_128_encipher_block;
`ifdef AES_ENC_PARALLEL_SBOX_EN
    localparam int LAT  = 21;
    localparam int STEP = 2;
`else
    localparam int LAT  = 51;
    localparam int STEP = 5;
`endif
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] INIT_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RK10_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    aes_128_encipher_block_if bus();
    aes_128_encipher_block dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab [11];
    logic [127:0] cur_key = '0;
    int n_checks = 0;
    int n_fail   = 0;

    // Key memory model: round key looked up from the round index the DUT exposes.
    assign bus.round_key = (bus.round <= 4'd10) ? rk_tab[bus.round] : '0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [127:0] round_key_of(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] rk, o;
        rk = round_key_of(key, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk[127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbox_tab[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[0][c] = gmul(8'd2, t[0][c]) ^ gmul(8'd3, t[1][c]) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(8'd2, t[1][c]) ^ gmul(8'd3, t[2][c]) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'd2, t[2][c]) ^ gmul(8'd3, t[3][c]);
                    s[3][c] = gmul(8'd3, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'd2, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
            rk = round_key_of(key, rnd);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] ^= rk[127-8*(4*c+r) -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, sb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                sb[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
            sbox_tab[x] = sb ^ 8'h63;
        end
    endtask

    task automatic set_key(input logic [127:0] k);
        cur_key = k;
        for (int r = 0; r <= 10; r++) rk_tab[r] = round_key_of(k, r);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: edges since the accepted start decide ready/round.
    bit           m_busy  = 0;
    int           m_k     = 0;
    logic         m_ready = 1'b1;
    logic [3:0]   m_round = '0;
    logic [127:0] m_nb = '0, m_init = '0, m_result = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_k = 0; m_ready = 1'b1; m_round = '0; m_nb = '0;
        end else if (!m_busy) begin
            if (bus.next) begin
                m_busy = 1; m_k = 0; m_ready = 1'b0; m_round = '0;
            end
        end else begin
            m_k++;
            if (m_k == 1) begin
                m_init   = bus.block ^ round_key_of(cur_key, 0);
                m_result = aes_enc(bus.block, cur_key);
            end
            m_round = 4'((1 + (m_k - 1) / STEP) > 10 ? 10 : (1 + (m_k - 1) / STEP));
            if (m_k == LAT) begin
                m_busy = 0; m_ready = 1'b1; m_nb = m_result;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("ready", 128'(bus.ready), 128'(m_ready));
            check("round", 128'(bus.round), 128'(m_round));
            if (!m_busy)          check("new_block_idle", bus.new_block, m_nb);
            else if (m_k == 1)    check("new_block_init", bus.new_block, m_init);
        end
    end

    // Starts a run, counts busy cycles and checks optional pinned literals.
    task automatic run_measure(input string tag, input logic [127:0] exp_ct,
                               input bit has_init, input logic [127:0] exp_init,
                               input bit has_rk10, input logic [127:0] exp_rk10);
        int low = 0;
        bit done = 0;
        @(posedge clk); #1 bus.next = 1'b1;
        @(posedge clk); #1 bus.next = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.ready) done = 1;
            else begin
                if (has_init && low == 1) check({tag, "_init"}, bus.new_block, exp_init);
                if (has_rk10 && low == LAT - 1) begin
                    check({tag, "_final_round"}, 128'(bus.round), 128'd10);
                    check({tag, "_final_key"}, bus.round_key, exp_rk10);
                end
                low++;
            end
        end
        check({tag, "_done"}, 128'(done), 128'd1);
        check({tag, "_busy_cycles"}, 128'(low), 128'(LAT));
        check({tag, "_ciphertext"}, bus.new_block, exp_ct);
        $display("run %s: busy=%0d ct=%h", tag, low, bus.new_block);
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.ready == lvl) ok = 1;
        end
        check({tag, "_wait"}, 128'(ok), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk, rb;
        bus.next = 1'b0;
        bus.block = PT_B;
        build_sbox();
        set_key(KEY_B);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("reset_new_block", bus.new_block, 128'd0);
        check("reset_round", 128'(bus.round), 128'd0);
        check("reset_ready", 128'(bus.ready), 128'd1);
        $display("reset: nb=%h round=%0d ready=%0d", bus.new_block, bus.round, bus.ready);

        run_measure("appB", CT_B, 1, INIT_B, 0, '0);

        set_key(KEY_C);
        bus.block = PT_C;
        run_measure("appC1", CT_C, 0, '0, 1, RK10_C);

        // Start pulses at E0+10 and E0+30 must be ignored.
        set_key(KEY_B);
        bus.block = PT_B;
        fork
            run_measure("ignore_next", CT_B, 0, '0, 0, '0);
            begin
                repeat (2) @(posedge clk);
                repeat (9) @(posedge clk); #1 bus.next = 1'b1;
                @(posedge clk); #1 bus.next = 1'b0;
                repeat (19) @(posedge clk); #1 bus.next = 1'b1;
                @(posedge clk); #1 bus.next = 1'b0;
            end
        join

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1 bus.next = 1'b1;
        @(posedge clk); #1 bus.next = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_new_block", bus.new_block, 128'd0);
        check("midreset_round", 128'(bus.round), 128'd0);
        check("midreset_ready", 128'(bus.ready), 128'd1);
        $display("mid-run reset: nb=%h round=%0d ready=%0d", bus.new_block, bus.round, bus.ready);
        @(negedge clk) reset_n = 1'b1;
        run_measure("appB_after_reset", CT_B, 1, INIT_B, 0, '0);

        // Back-to-back runs with next held high.
        @(posedge clk); #1 bus.next = 1'b1;
        wait_ready(1'b0, "b2b_first_start");
        wait_ready(1'b1, "b2b_first_end");
        check("b2b_first_ct", bus.new_block, CT_B);
        bus.block = PT_C;
        @(negedge clk);
        check("b2b_ready_gap", 128'(bus.ready), 128'd0);
        wait_ready(1'b1, "b2b_second_end");
        bus.next = 1'b0;
        check("b2b_second_ct", bus.new_block, aes_enc(PT_C, KEY_B));
        $display("back-to-back: second ct=%h", bus.new_block);

        for (int n = 0; n < 6; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            set_key(rk);
            bus.block = rb;
            run_measure($sformatf("random%0d", n), aes_enc(rb, rk), 1, rb ^ rk, 0, '0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
